// File: rtl/excess3_serial_adder.sv
// Digit-serial Excess-3 adder/subtractor, one digit per clock, LSD first.
// Subtraction adds the 9's complement of B with an initial carry of 1.
module excess3_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W = 4 * DIGITS;
  localparam logic [4:0] LAST = 5'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [W-1:0] a_r, b_r, acc;
  logic [W+3:0] acc_nx;
  logic [4:0]   idx;
  logic [4:0]   t;
  logic [3:0]   dig;
  logic         carry;
  logic         bad;
  logic         bad_in;
  logic         last;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i+:4] < 4'd3 || a[4*i+:4] > 4'd12 ||
          b[4*i+:4] < 4'd3 || b[4*i+:4] > 4'd12)
        bad_in = 1'b1;
    end
  end

  // Excess-3 correction: +3 on decimal carry, -3 otherwise
  always_comb begin
    t      = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0, carry};
    dig    = t[4] ? t[3:0] + 4'd3 : t[3:0] - 4'd3;
    acc_nx = {dig, acc};
    last   = (idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      bad   <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
      acc   <= '0;
      bad   <= bad_in;
    end else if (state == RUN) begin
      a_r   <= a_r >> 4;
      b_r   <= b_r >> 4;
      carry <= t[4];
      idx   <= idx + 5'd1;
      acc   <= acc_nx[W+3:4];
      if (last) begin
        sum  <= acc_nx[W+3:4];
        cout <= t[4];
        err  <= bad;
      end
    end
  end

endmodule

// File: tb/tb_excess3_serial_adder.sv
// Bench for excess3_serial_adder: decimal reference model with a
// cycle-accurate schedule, plus directed literal cases and random traffic.
module tb_excess3_serial_adder;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         cout, busy, done, err;

  int n_chk = 0;
  int n_fail = 0;

  excess3_serial_adder #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference: decode digits, do the arithmetic, re-encode
  function automatic void ref_op(input logic [W-1:0] ra, rb,
                                 input logic rs, rc,
                                 output logic [W-1:0] r,
                                 output logic co, e);
    longint va, vb, m, res;
    int da, db;
    va = 0; vb = 0; m = 1; e = 1'b0;
    for (int i = 0; i < D; i++) begin
      da = int'(ra[4*i+:4]);
      db = int'(rb[4*i+:4]);
      if (da < 3 || da > 12 || db < 3 || db > 12) e = 1'b1;
      va += longint'(da - 3) * m;
      vb += longint'(db - 3) * m;
      m *= 10;
    end
    if (rs) begin
      res = va - vb;
      co = (res >= 0);
      if (res < 0) res += m;
    end else begin
      res = va + vb + longint'(rc);
      co = (res >= m);
      if (co) res -= m;
    end
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i+:4] = 4'(res % 10 + 3);
      res /= 10;
    end
  endfunction

  // Schedule model: cycles elapsed since the accepting edge
  int           cnt = 0;
  logic [W-1:0] p_sum, e_sum;
  logic         p_co, p_err, e_co, e_err, e_known;

  always @(posedge clk) begin
    if (rst) begin
      cnt = 0;
      e_sum = '0; e_co = 1'b0; e_err = 1'b0; e_known = 1'b1;
    end else if (cnt == D + 1) begin
      cnt = 0;
    end else if (cnt > 0) begin
      cnt++;
      if (cnt == D + 1) begin
        e_sum = p_sum; e_co = p_co; e_err = p_err;
        e_known = !p_err;
      end
    end else if (start) begin
      ref_op(a, b, sub, cin, p_sum, p_co, p_err);
      cnt = 1;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(cnt >= 1 && cnt <= D));
      chk("done", 64'(done), 64'(cnt == D + 1));
      chk("err", 64'(err), 64'(e_err));
      if (e_known) begin
        chk("sum", 64'(sum), 64'(e_sum));
        chk("cout", 64'(cout), 64'(e_co));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, tb_, input logic ts, tc,
                        input logic [W-1:0] xs, input logic xc, xe,
                        input logic chk_sum, input string tag);
    int n;
    bit seen;
    @(posedge clk); #1;
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_; sub = ~ts; cin = ~tc;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk({tag, "_timeout"}, 64'(seen), 64'(1));
    if (seen) begin
      chk({tag, "_lat"}, 64'(n), 64'(D + 1));
      chk({tag, "_err"}, 64'(err), 64'(xe));
      if (chk_sum) begin
        chk({tag, "_sum"}, 64'(sum), 64'(xs));
        chk({tag, "_cout"}, 64'(cout), 64'(xc));
      end
    end
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_flags", 64'({busy, done, cout, err}), 64'(0));

    run_op(16'h4567, 16'h89AB, 0, 0, 16'h9C45, 0, 0, 1, "add1");
    run_op(16'hCCCC, 16'h3334, 0, 0, 16'h3333, 1, 0, 1, "add2");
    run_op(16'h89AB, 16'h4567, 1, 0, 16'h7777, 1, 0, 1, "sub1");
    run_op(16'h4567, 16'h89AB, 1, 0, 16'h8889, 0, 0, 1, "sub2");
    run_op(16'h4560, 16'h89AB, 0, 0, 16'h0, 0, 1, 0, "bad");
    run_op(16'h3333, 16'h3333, 0, 1, 16'h3334, 0, 0, 1, "cin");

    // Reset on the second RUN cycle aborts without a done pulse
    @(posedge clk); #1;
    a = 16'h4567; b = 16'h89AB; sub = 0; cin = 0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_sum", 64'(sum), 64'(0));
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_nodone", 64'(dones), 64'(0));

    // Second start during RUN is ignored
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("one_done", 64'(dones), 64'(1));

    // Random traffic, checked cycle by cycle against the model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < D; i++) begin
        a[4*i+:4] = 4'($urandom_range(12, 3));
        b[4*i+:4] = 4'($urandom_range(12, 3));
      end
      if ($urandom_range(7, 0) == 0) a[4*$urandom_range(D-1, 0)+:4] = 4'($urandom_range(2, 0));
      if ($urandom_range(9, 0) == 0) b[4*$urandom_range(D-1, 0)+:4] = 4'($urandom_range(15, 13));
      sub = 1'($urandom);
      cin = 1'($urandom);
      start = ($urandom_range(2, 0) == 0);
      rst = ($urandom_range(59, 0) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/excess3_serial_adder.md
EXCESS3_SERIAL_ADDER -- requirements
Module: excess3_serial_adder

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of Excess-3 digits per operand (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 = A+B+cin, 1 = A-B; sampled with start.
REQ-006 The block SHALL have port a, input, 4*DIGITS bits: operand A as Excess-3 digits, digit 0 in a[3:0].
REQ-007 The block SHALL have port b, input, 4*DIGITS bits: operand B as Excess-3 digits, same layout as a.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 The block SHALL have port sum, output, 4*DIGITS bits: registered Excess-3 result.
REQ-010 The block SHALL have port cout, output, 1 bit: registered carry out of the most significant digit (sub=1: 1 = no borrow).
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-013 The block SHALL have port err, output, 1 bit: high with done if any A or B digit is outside 4'b0011..4'b1100.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; after reset it SHALL be in IDLE.
REQ-015 In IDLE, start=1 SHALL latch a, b, sub and cin into internal registers and enter RUN with digit index 0.
REQ-016 The carry register SHALL load cin when sub=0 and 1 when sub=1.
REQ-017 When sub=1, each B digit SHALL be bitwise inverted before addition, forming the Excess-3 9's complement.
REQ-018 In RUN, one digit per clock SHALL be processed, least-significant digit first.
REQ-019 Per digit, t = Ad + Bd' + carry SHALL be formed as a 5-bit value; if t >= 16 the digit result SHALL be (t[3:0] + 3) mod 16 with carry=1, otherwise (t[3:0] - 3) mod 16 with carry=0.
REQ-020 After digit DIGITS-1 the FSM SHALL enter DONE; cout SHALL take the final carry, sum SHALL hold all digit results, and err SHALL be set per REQ-013.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 Latency SHALL be fixed: done=1 in the DIGITS+1-th cycle after the cycle in which start is sampled high, with busy=1 for exactly DIGITS cycles.
REQ-023 sum, cout and err SHALL hold their values from DONE until the next DONE or reset.
REQ-024 start SHALL be ignored in RUN and in DONE; a new operation SHALL be accepted only from IDLE, which gives a minimum issue interval of DIGITS+2 cycles.
REQ-025 Changes on a, b, sub or cin after start is sampled SHALL NOT affect the result in progress.
REQ-026 Invalid digits SHALL NOT abort the operation; the arithmetic of REQ-019 SHALL still be applied.

Reset
REQ-027 When rst=1 at a clock edge, the state SHALL go to IDLE and sum, cout, busy, done, err and all internal registers SHALL be cleared to 0.
REQ-028 rst SHALL take priority over start and over any operation in progress; an aborted operation SHALL produce no done pulse.

Verification (DIGITS=4)
REQ-029 The bench SHALL check: a=16'h4567 (1234), b=16'h89AB (5678), sub=0, cin=0 -> sum=16'h9C45, cout=0, done exactly 5 cycles after start.
REQ-030 The bench SHALL check: a=16'hCCCC (9999), b=16'h3334 (0001), sub=0, cin=0 -> sum=16'h3333, cout=1.
REQ-031 The bench SHALL check: a=16'h89AB (5678), b=16'h4567 (1234), sub=1 -> sum=16'h7777 (4444), cout=1; swapped operands -> cout=0.
REQ-032 The bench SHALL check: a=16'h4560 (digit 0 = 4'b0000), any valid b -> err=1 with done; a fully valid operation afterwards -> err=0.
REQ-033 The bench SHALL check: rst asserted on the 2nd RUN cycle -> next cycle busy=0 and sum=0, no done pulse; a start pulse during RUN is ignored and yields only one done.
